seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for the 5-digit common-select seven-segment display.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg7_hex_decode.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Seven-segment pattern constants and output-bus layout shared by
//            the scan controller and its hex decoder.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // SEG_DATA is {dp, g, f, e, d, c, b, a}
    localparam int SEG_DATA_W = 8;
    localparam int SEG_DP_BIT = 7;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decode
// Purpose  : Combinational 4-bit hex value to 7-segment pattern {g..a}.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    // Hex glyph lookup; lower-case b and d keep them distinct from 8 and 0
    always_comb begin
        pattern = SEG_BLANK;
        case (value)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            4'hF: pattern = SEG_F;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a common-select 7-segment
//            display. Double-buffered frame (shadow/active) committed only at
//            a frame boundary so the visible image never tears.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  commit_req,
    output logic                  commit_ack,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [NUM_DIGITS-1:0] SEG_SEL,
    output logic [SEG_DATA_W-1:0] SEG_DATA
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [PW-1:0]         PRESC_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]         PRESC_BLANK = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE     = NUM_DIGITS'(1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [3:0]            r_shadow_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [3:0]            r_active_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic                  r_pending;

    logic                  w_tc;
    logic                  w_boundary;
    logic                  w_xfer;
    logic                  w_wr_ok;
    logic                  w_dark;
    logic [3:0]            w_cur_val;
    logic                  w_cur_dp;
    logic [6:0]            w_pattern;

    // Slot/frame timing and the transfer decision; while disabled there is
    // no frame to wait for, so a pending commit transfers immediately
    always_comb begin
        w_tc       = en && (r_presc == PRESC_LAST);
        w_boundary = w_tc && (r_idx == IDX_LAST);
        w_xfer     = r_pending && (en ? w_boundary : 1'b1);
        w_wr_ok    = wr_en && (int'(wr_addr) < NUM_DIGITS);
        w_cur_val  = r_active_val[r_idx];
        w_cur_dp   = r_active_dp[r_idx];
        w_dark     = !en || (r_presc < PRESC_BLANK) || blank_mask[r_idx];
    end

    seg7_hex_decode u_decode (
        .value   (w_cur_val),
        .pattern (w_pattern)
    );

    // Prescaler and digit index; disabling parks the scan at digit 0, slot start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (!en) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Shadow frame: host writes land here; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow_val[i] <= '0;
            end
            r_shadow_dp <= '0;
        end else if (w_wr_ok) begin
            r_shadow_val[wr_addr] <= wr_data;
            r_shadow_dp[wr_addr]  <= wr_dp;
        end
    end

    // Active frame, pending flag and ack; the copy samples the registered
    // shadow, so a write on the transfer cycle misses this transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_active_val[i] <= '0;
            end
            r_active_dp <= '0;
            r_pending   <= 1'b0;
            commit_ack  <= 1'b0;
        end else begin
            commit_ack <= w_xfer;
            if (w_xfer) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active_val[i] <= r_shadow_val[i];
                end
                r_active_dp <= r_shadow_dp;
                r_pending   <= commit_req;
            end else if (commit_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Registered display drive for the digit currently being scanned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SEG_SEL  <= '0;
            SEG_DATA <= '0;
        end else if (w_dark) begin
            SEG_SEL  <= '0;
            SEG_DATA <= '0;
        end else begin
            SEG_SEL  <= SEL_ONE << r_idx;
            SEG_DATA <= {w_cur_dp, w_pattern};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl with small scan timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int ND = 5;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FRAME = RD * ND;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [3:0]    wr_data;
    logic          wr_dp;
    logic          commit_req;
    logic          commit_ack;
    logic [ND-1:0] blank_mask;
    logic [ND-1:0] SEG_SEL;
    logic [7:0]    SEG_DATA;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .blank_mask (blank_mask),
        .SEG_SEL    (SEG_SEL),
        .SEG_DATA   (SEG_DATA)
    );

    always #5 clk = ~clk;

    // Glyph table {g..a} for 0..F
    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: frames, pending request, enabled-cycle count
    logic [3:0] m_sh_val [ND];
    logic       m_sh_dp  [ND];
    logic [3:0] m_ac_val [ND];
    logic       m_ac_dp  [ND];
    bit         m_pend;
    int         m_k;

    logic [13:0] exp_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check_now(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed sel=%b data=%h ack=%b, expected sel=%b data=%h ack=%b",
                   tag, obs[13:9], obs[8:1], obs[0], exp[13:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_sh_val[i] = '0;
            m_sh_dp[i]  = 1'b0;
            m_ac_val[i] = '0;
            m_ac_dp[i]  = 1'b0;
        end
        m_pend = 1'b0;
        m_k    = 0;
    endtask

    // One clock: predict the post-edge outputs from the current inputs, queue
    // them, advance the reference frame state, then compare after the edge
    task automatic step(input string tag);
        logic [4:0] esel;
        logic [7:0] edat;
        int         pos;
        int         dig;
        bit         bnd;
        bit         xfer;
        esel = '0;
        edat = '0;
        bnd  = 1'b0;
        if (en) begin
            pos = m_k % RD;
            dig = (m_k / RD) % ND;
            if (pos >= BC && !blank_mask[dig]) begin
                esel = 5'(1) << dig;
                edat = {m_ac_dp[dig], dec_tab[m_ac_val[dig]]};
            end
            bnd = ((m_k % FRAME) == FRAME - 1);
            m_k++;
        end else begin
            m_k = 0;
        end
        xfer = m_pend && (en ? bnd : 1'b1);
        exp_q.push_back({esel, edat, xfer});
        if (xfer) begin
            for (int i = 0; i < ND; i++) begin
                m_ac_val[i] = m_sh_val[i];
                m_ac_dp[i]  = m_sh_dp[i];
            end
        end
        if (wr_en && int'(wr_addr) < ND) begin
            m_sh_val[wr_addr] = wr_data;
            m_sh_dp[wr_addr]  = wr_dp;
        end
        m_pend = xfer ? commit_req : (m_pend | commit_req);
        @(posedge clk);
        @(negedge clk);
        check_now(tag, {SEG_SEL, SEG_DATA, commit_ack}, exp_q.pop_front());
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic dp, input logic with_commit);
        wr_en      = 1'b1;
        wr_addr    = a;
        wr_data    = d;
        wr_dp      = dp;
        commit_req = with_commit;
        step("write");
        wr_en      = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic commit(input string tag);
        commit_req = 1'b1;
        step(tag);
        commit_req = 1'b0;
    endtask

    // Advance until the next edge is the frame boundary (bounded)
    task automatic to_boundary();
        int guard = 0;
        while (!(en && (m_k % FRAME) == FRAME - 1) && guard < 2 * FRAME) begin
            step("align");
            guard++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_dp      = 1'b0;
        commit_req = 1'b0;
        blank_mask = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_now("reset_state", {SEG_SEL, SEG_DATA, commit_ack}, 14'd0);
        rst_n = 1'b1;

        // Basic scan of an all-zero frame
        en = 1'b1;
        run(24, "scan_zero");

        // Mid-frame commit; write and commit on the same cycle for digit 4
        run(5, "pre_write");
        wr(3'd0, 4'h3, 1'b1, 1'b0);
        wr(3'd4, 4'hF, 1'b0, 1'b1);
        run(45, "commit_frame");

        // Write on the exact transfer cycle misses that transfer
        commit("commit_a");
        to_boundary();
        wr(3'd1, 4'h7, 1'b0, 1'b0);
        run(22, "old_digit1");
        commit("commit_b");
        run(42, "new_digit1");

        // Two requests within one frame merge into a single ack
        to_boundary();
        step("post_bnd");
        commit("merge_1");
        run(3, "merge_gap");
        commit("merge_2");
        run(25, "merge_frame");

        // Out-of-range addresses leave the shadow untouched
        wr(3'd5, 4'h2, 1'b1, 1'b0);
        wr(3'd7, 4'h2, 1'b1, 1'b0);
        commit("bad_addr");
        run(42, "bad_addr_frame");

        // Commit requested on the transfer cycle starts a new pending
        commit("edge_a");
        to_boundary();
        wr(3'd2, 4'hA, 1'b0, 1'b1);
        run(42, "edge_frame");

        // Live blanking of digit 2
        blank_mask = 5'b00100;
        run(22, "blank_mask");
        blank_mask = '0;

        // Disable mid-slot, commit while dark, re-enable
        to_boundary();
        run(6, "pre_dis");
        en = 1'b0;
        run(2, "disabled");
        wr(3'd3, 4'hC, 1'b0, 1'b0);
        commit("dark_commit");
        run(3, "dark_ack");
        en = 1'b1;
        run(12, "reenable");

        // Reset while a commit is pending: outputs clear at once, no ack
        commit("lost_commit");
        run(2, "pending");
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", {SEG_SEL, SEG_DATA, commit_ack}, 14'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_now("reset_hold", {SEG_SEL, SEG_DATA, commit_ack}, 14'd0);
        rst_n = 1'b1;
        run(45, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
